clint_multi: RTL and testbench
==============================

// Module: clint_multi
// PURPOSE
//   Parametrised core-local interruptor on the AXI4 (single-beat) MMIO bus.
//   Holds a 64-bit prescaled mtime, one mtimecmp and one msip register per hart,
//   and drives per-hart timer (mtip) and software (msip) interrupt lines to the cores.
//   Unlike the read-only timer it replaces, all registers are writable (byte strobes).
// PARAMETERS
//   BASE_ADDR  32'h1001_0000  base of the 64 KiB register window
//   NUM_HARTS  1              harts served, 1..16
//   TICK_DIV   1              clk cycles per mtime increment, >=1
//   ID_W       4              AXI ID width
// PORTS
//   clk      in   1             clock, all logic on posedge
//   rst_n    in   1             asynchronous active-low reset
//   arvalid/arready  in/out 1   AR handshake; araddr in 32; arid in ID_W; arlen in 8; arsize in 3; arburst in 2
//   rvalid/rready    out/in 1   R handshake; rdata out 32; rresp out 2; rid out ID_W; rlast out 1
//   awvalid/awready  in/out 1   AW handshake; awaddr in 32; awid in ID_W; awlen in 8; awsize in 3; awburst in 2
//   wvalid/wready    in/out 1   W handshake; wdata in 32; wstrb in 4; wlast in 1
//   bvalid/bready    out/in 1   B handshake; bresp out 2; bid out ID_W
//   mtip     out  NUM_HARTS     per-hart machine timer interrupt pending
//   msip     out  NUM_HARTS     per-hart machine software interrupt pending
// BEHAVIOUR
//   Map (offset from BASE_ADDR, word aligned): 0x0000+4h msip[h] (bit0 only, rest RAZ/WI);
//   0x4000+8h mtimecmp[h] lo, 0x4004+8h hi; 0xBFF8 mtime lo, 0xBFFC hi. h < NUM_HARTS.
//   Unmapped = outside window, h >= NUM_HARTS, addr[1:0]!=0, or len!=0 -> SLVERR (2'b10),
//   rdata 0, no state change. Mapped -> OKAY (2'b00). arsize/arburst/awsize/awburst ignored.
//   Reset (rst_n low, async): rvalid/bvalid 0, rdata 0, rresp/bresp OKAY, rid/bid 0,
//   mtime 0, prescaler 0, mtimecmp[*] 64'hFFFF_FFFF_FFFF_FFFF, msip 0, mtip 0.
//   Read: arready = !rvalid. ar_fire latches arid; rvalid, rdata, rresp set next edge
//   (1-cycle latency), held until r_fire; rlast = rvalid; rid = latched arid.
//   Write: awready = !bvalid && !aw_seen; wready = !bvalid && !w_seen; AW and W accepted
//   in either order or same cycle; awaddr/awid/awlen latched on aw_fire, wdata/wstrb on
//   the w_fire carrying wlast (earlier beats of an illegal burst are consumed, discarded).
//   On the edge where both are complete and !bvalid: register update (byte-wise per
//   wstrb) and bvalid<=1 with bresp; aw_seen/w_seen clear; bvalid held until b_fire.
//   Prescaler counts 0..TICK_DIV-1, wraps; mtime += 1 on the wrap cycle (every cycle
//   when TICK_DIV=1). mtime wraps 2^64-1 -> 0. A write to mtime wins over the
//   increment in the same cycle; prescaler keeps counting. Writing one half leaves the
//   other half unchanged (no carry between halves on write).
//   mtip[h] registered: next edge <= (mtime >= mtimecmp[h]), 64-bit unsigned, evaluated
//   on current register values -> 1-cycle lag after mtime/mtimecmp changes. msip output =
//   msip register bit.
//   Read and write to same register in same cycle: read returns pre-write value.
//   Reset mid-transaction aborts it; no response is produced for it afterwards.
// TESTING
//   1 Reset, TICK_DIV=1: read 0xBFF8 on 5th cycle after rst_n rise -> OKAY, rdata
//     equals cycle count since reset; read 0xBFFC -> 0; mtip=0.
//   2 NUM_HARTS=2: write mtimecmp[1]=0x40 (lo 0x40, hi 0) -> mtip[1] rises exactly one
//     cycle after mtime reaches 0x40, mtip[0] stays 0; write hi=0xFFFF_FFFF -> mtip[1]
//     falls one cycle later.
//   3 Write msip[0]=0xFFFF_FFFF wstrb 4'b0001 -> msip[0]=1, readback 0x1; write 0 -> 0.
//   4 Write mtime lo=0xFFFF_FFFE, hi=0xFFFF_FFFF, TICK_DIV=1 -> mtime wraps to 0 two
//     cycles after lo write; W beat before AW and AW/W same cycle both give OKAY, bid=awid.
//   5 Read 0x4008 with NUM_HARTS=1, read 0x0002, write with awlen=3 (4 beats) -> SLVERR,
//     rdata 0, no register changes, all 4 W beats accepted, one B.
//   6 TICK_DIV=4: mtime increments once per 4 cycles; rready held low 10 cycles ->
//     rvalid/rdata stable, arready low throughout; rst_n pulsed mid-write -> all reset values.

Source files
------------

// File: rtl/clint_multi_if.sv
// AXI4 single-beat MMIO bus bundle for the core-local interruptor.
interface clint_multi_if #(
    parameter int unsigned ID_W = 4
);
    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;

    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic [ID_W-1:0] rid;
    logic            rlast;

    logic            awvalid;
    logic            awready;
    logic [31:0]     awaddr;
    logic [ID_W-1:0] awid;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;

    logic            wvalid;
    logic            wready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;

    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        input  arready, rvalid, rdata, rresp, rid, rlast,
        input  awready, wready, bvalid, bresp, bid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        output arready, rvalid, rdata, rresp, rid, rlast,
        output awready, wready, bvalid, bresp, bid
    );
endinterface

// File: rtl/clint_multi.sv
// Multi-hart core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp
// and msip, all writable over a single-beat AXI4 slave.
module clint_multi #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned ID_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clint_multi_if.slave         bus,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip
);
    localparam int unsigned HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [11:0] NH = 12'(NUM_HARTS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {K_MSIP, K_CMP, K_TIME} kind_e;

    typedef struct packed {
        logic          ok;
        kind_e         kind;
        logic [HW-1:0] hart;
        logic          hi;
    } dec_t;

    // Address/length decode into register kind, hart index and word half.
    function automatic dec_t decode(input logic [31:0] addr, input logic [7:0] len);
        dec_t        d;
        logic [15:0] off;
        logic [15:0] rel;
        logic [11:0] hidx;
        logic        mapped;
        d      = '0;
        off    = addr[15:0];
        rel    = off - 16'h4000;
        hidx   = '0;
        mapped = 1'b0;
        if (off < 16'h4000) begin
            d.kind = K_MSIP;
            hidx   = off[13:2];
            mapped = (hidx < NH);
        end else if (off < 16'hBFF8) begin
            d.kind = K_CMP;
            hidx   = rel[14:3];
            mapped = (hidx < NH);
        end else if (off[15:3] == 13'h17FF) begin
            d.kind = K_TIME;
            mapped = 1'b1;
        end
        d.hart = HW'(hidx);
        d.hi   = off[2];
        d.ok   = mapped && (addr[31:16] == BASE_ADDR[31:16]) &&
                 (off[1:0] == 2'b00) && (len == 8'd0);
        return d;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) m[8*b +: 8] = wd[8*b +: 8];
        end
        return m;
    endfunction

    logic [PW-1:0]   presc_q;
    logic [63:0]     mtime_q;
    logic [63:0]     mtimecmp_q [NUM_HARTS];

    logic            rvalid_q;
    logic [31:0]     rdata_q;
    logic [1:0]      rresp_q;
    logic [ID_W-1:0] rid_q;

    logic            aw_seen_q, w_seen_q, bvalid_q;
    logic [31:0]     awaddr_q, wdata_q;
    logic [ID_W-1:0] awid_q, bid_q;
    logic [7:0]      awlen_q;
    logic [3:0]      wstrb_q;
    logic [1:0]      bresp_q;

    logic            tick_c, ar_fire_c, r_fire_c, aw_fire_c, wl_fire_c, wr_go_c;
    logic            awready_c, wready_c;
    logic [31:0]     waddr_c, wdata_c, rd_c;
    logic [ID_W-1:0] wid_c;
    logic [7:0]      wlen_c;
    logic [3:0]      wstrb_c;
    dec_t            rdec_c, wdec_c;
    logic            unused_c;

    assign unused_c  = ^{bus.arsize, bus.arburst, bus.awsize, bus.awburst};

    assign tick_c    = (presc_q == PW'(TICK_DIV - 1));
    assign ar_fire_c = bus.arvalid && !rvalid_q;
    assign r_fire_c  = rvalid_q && bus.rready;
    assign awready_c = !bvalid_q && !aw_seen_q;
    assign wready_c  = !bvalid_q && !w_seen_q;
    assign aw_fire_c = bus.awvalid && awready_c;
    assign wl_fire_c = bus.wvalid && wready_c && bus.wlast;
    assign wr_go_c   = (aw_seen_q || aw_fire_c) && (w_seen_q || wl_fire_c) && !bvalid_q;

    // Write command comes from the latch once captured, else straight off the bus.
    assign waddr_c = aw_seen_q ? awaddr_q : bus.awaddr;
    assign wid_c   = aw_seen_q ? awid_q   : bus.awid;
    assign wlen_c  = aw_seen_q ? awlen_q  : bus.awlen;
    assign wdata_c = w_seen_q  ? wdata_q  : bus.wdata;
    assign wstrb_c = w_seen_q  ? wstrb_q  : bus.wstrb;

    assign rdec_c = decode(bus.araddr, bus.arlen);
    assign wdec_c = decode(waddr_c, wlen_c);

    always_comb begin
        rd_c = '0;
        if (rdec_c.ok) begin
            case (rdec_c.kind)
                K_MSIP:  rd_c = {31'b0, msip[rdec_c.hart]};
                K_CMP:   rd_c = rdec_c.hi ? mtimecmp_q[rdec_c.hart][63:32]
                                          : mtimecmp_q[rdec_c.hart][31:0];
                K_TIME:  rd_c = rdec_c.hi ? mtime_q[63:32] : mtime_q[31:0];
                default: rd_c = '0;
            endcase
        end
    end

    assign bus.arready = !rvalid_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rid     = rid_q;
    assign bus.rlast   = rvalid_q;
    assign bus.awready = awready_c;
    assign bus.wready  = wready_c;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bid     = bid_q;

    // Read channel: one-cycle latency, response held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rid_q    <= '0;
        end else if (ar_fire_c) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_c;
            rresp_q  <= rdec_c.ok ? RESP_OKAY : RESP_SLVERR;
            rid_q    <= bus.arid;
        end else if (r_fire_c) begin
            rvalid_q <= 1'b0;
        end
    end

    // Write channel: collect AW and last W in any order, then respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_seen_q <= 1'b0;
            w_seen_q  <= 1'b0;
            awaddr_q  <= '0;
            awid_q    <= '0;
            awlen_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
        end else begin
            if (aw_fire_c) begin
                awaddr_q <= bus.awaddr;
                awid_q   <= bus.awid;
                awlen_q  <= bus.awlen;
            end
            if (wl_fire_c) begin
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
            if (wr_go_c) begin
                aw_seen_q <= 1'b0;
                w_seen_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wdec_c.ok ? RESP_OKAY : RESP_SLVERR;
                bid_q     <= wid_c;
            end else begin
                if (aw_fire_c) aw_seen_q <= 1'b1;
                if (wl_fire_c) w_seen_q  <= 1'b1;
                if (bvalid_q && bus.bready) bvalid_q <= 1'b0;
            end
        end
    end

    // Prescaled time base; a bus write to either half beats the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= tick_c ? '0 : presc_q + PW'(1);
            if (wr_go_c && wdec_c.ok && wdec_c.kind == K_TIME) begin
                if (wdec_c.hi) mtime_q[63:32] <= merge(mtime_q[63:32], wdata_c, wstrb_c);
                else           mtime_q[31:0]  <= merge(mtime_q[31:0], wdata_c, wstrb_c);
            end else if (tick_c) begin
                mtime_q <= mtime_q + 64'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip <= '0;
            for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
        end else if (wr_go_c && wdec_c.ok) begin
            if (wdec_c.kind == K_MSIP && wstrb_c[0]) msip[wdec_c.hart] <= wdata_c[0];
            if (wdec_c.kind == K_CMP) begin
                if (wdec_c.hi)
                    mtimecmp_q[wdec_c.hart][63:32] <= merge(mtimecmp_q[wdec_c.hart][63:32],
                                                            wdata_c, wstrb_c);
                else
                    mtimecmp_q[wdec_c.hart][31:0]  <= merge(mtimecmp_q[wdec_c.hart][31:0],
                                                            wdata_c, wstrb_c);
            end
        end
    end

    // Timer compare on current register values, so mtip lags by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtip <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) mtip[h] <= (mtime_q >= mtimecmp_q[h]);
        end
    end
endmodule

// File: tb/tb_clint_multi.sv
// Directed bench: dut0 is two harts at full rate, dut1 one hart with a /4 prescaler.
module tb_clint_multi;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sel   = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tot  = 0;
    int n_bad  = 0;
    int t_last = 0;

    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [3:0]  arid = '0, awid = '0, wstrb = '0;
    logic [7:0]  arlen = '0, awlen = '0;
    logic        wlast = 1'b0;

    clint_multi_if #(.ID_W(4)) b0 ();
    clint_multi_if #(.ID_W(4)) b1 ();

    logic [1:0] mtip0, msip0;
    logic [0:0] mtip1, msip1;

    clint_multi #(.BASE_ADDR(BASE), .NUM_HARTS(2), .TICK_DIV(1), .ID_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0), .mtip(mtip0), .msip(msip0));
    clint_multi #(.BASE_ADDR(BASE), .NUM_HARTS(1), .TICK_DIV(4), .ID_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .mtip(mtip1), .msip(msip1));

    assign b0.arvalid = arvalid & ~sel;  assign b1.arvalid = arvalid & sel;
    assign b0.rready  = rready  & ~sel;  assign b1.rready  = rready  & sel;
    assign b0.awvalid = awvalid & ~sel;  assign b1.awvalid = awvalid & sel;
    assign b0.wvalid  = wvalid  & ~sel;  assign b1.wvalid  = wvalid  & sel;
    assign b0.bready  = bready  & ~sel;  assign b1.bready  = bready  & sel;
    assign b0.araddr = araddr;   assign b1.araddr = araddr;
    assign b0.arid   = arid;     assign b1.arid   = arid;
    assign b0.arlen  = arlen;    assign b1.arlen  = arlen;
    assign b0.arsize = 3'd2;     assign b1.arsize = 3'd2;
    assign b0.arburst = 2'b01;   assign b1.arburst = 2'b01;
    assign b0.awaddr = awaddr;   assign b1.awaddr = awaddr;
    assign b0.awid   = awid;     assign b1.awid   = awid;
    assign b0.awlen  = awlen;    assign b1.awlen  = awlen;
    assign b0.awsize = 3'd2;     assign b1.awsize = 3'd2;
    assign b0.awburst = 2'b01;   assign b1.awburst = 2'b01;
    assign b0.wdata  = wdata;    assign b1.wdata  = wdata;
    assign b0.wstrb  = wstrb;    assign b1.wstrb  = wstrb;
    assign b0.wlast  = wlast;    assign b1.wlast  = wlast;

    logic        arready_m, rvalid_m, rlast_m, awready_m, wready_m, bvalid_m;
    logic [31:0] rdata_m;
    logic [1:0]  rresp_m, bresp_m;
    logic [3:0]  rid_m, bid_m;
    assign arready_m = sel ? b1.arready : b0.arready;
    assign rvalid_m  = sel ? b1.rvalid  : b0.rvalid;
    assign rlast_m   = sel ? b1.rlast   : b0.rlast;
    assign rdata_m   = sel ? b1.rdata   : b0.rdata;
    assign rresp_m   = sel ? b1.rresp   : b0.rresp;
    assign rid_m     = sel ? b1.rid     : b0.rid;
    assign awready_m = sel ? b1.awready : b0.awready;
    assign wready_m  = sel ? b1.wready  : b0.wready;
    assign bvalid_m  = sel ? b1.bvalid  : b0.bvalid;
    assign bresp_m   = sel ? b1.bresp   : b0.bresp;
    assign bid_m     = sel ? b1.bid     : b0.bid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                      output logic [31:0] d, output logic [1:0] resp, output logic [3:0] rid_o);
        logic ok;
        int   n;
        araddr = a; arlen = len; arid = id; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        do begin ok = arready_m; tick(1); n++; end while (!ok && n < 50);
        arvalid = 1'b0;
        check("ar_accept", 64'(ok), 64'd1);
        n = 0;
        while (!rvalid_m && n < 50) begin tick(1); n++; end
        check("r_valid_last", {62'd0, rvalid_m, rlast_m}, 64'd3);
        d = rdata_m; resp = rresp_m; rid_o = rid_m;
        tick(1);
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
        logic ok;
        int   n;
        awaddr = a; awlen = len; awid = id; awvalid = 1'b1;
        n = 0;
        do begin ok = awready_m; tick(1); n++; end while (!ok && n < 50);
        awvalid = 1'b0;
        check("aw_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int beats,
                          output int nacc);
        logic ok;
        int   n;
        nacc = 0;
        for (int i = 0; i < beats; i++) begin
            wdata = d; wstrb = s; wlast = (i == beats - 1); wvalid = 1'b1;
            n = 0;
            do begin ok = wready_m; tick(1); n++; end while (!ok && n < 50);
            if (ok) nacc++;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic [3:0] id);
        int n;
        bready = 1'b1;
        n = 0;
        while (!bvalid_m && n < 50) begin tick(1); n++; end
        check("b_seen", 64'(bvalid_m), 64'd1);
        resp = bresp_m; id = bid_m;
        tick(1);
        bready = 1'b0;
    endtask

    // w_first=1 sends the W beat before AW, otherwise both in the same cycle.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [3:0] id, input bit w_first,
                      output logic [1:0] resp, output logic [3:0] bid_o);
        int nacc;
        if (w_first) begin
            send_w(d, s, 1, nacc);
            send_aw(a, 8'd0, id);
        end else begin
            fork
                send_aw(a, 8'd0, id);
                send_w(d, s, 1, nacc);
            join
        end
        t_last = cyc;
        wait_b(resp, bid_o);
    endtask

    logic [31:0] d, d1, d2, d3;
    logic [1:0]  rs, bs;
    logic [3:0]  ri, bi;
    int          t0, nacc;
    logic        flag;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values on both instances.
        tick(3);
        check("rst_rvalid", {b0.rvalid, b1.rvalid, b0.bvalid, b1.bvalid}, 64'd0);
        check("rst_rdata", {b0.rdata, b1.rdata}, 64'd0);
        check("rst_resp_id", {b0.rresp, b1.rresp, b0.bresp, b1.bresp,
                              b0.rid, b1.rid, b0.bid, b1.bid}, 64'd0);
        check("rst_irq", {mtip0, msip0, mtip1, msip1}, 64'd0);
        check("rst_ready", {b0.arready, b0.awready, b0.wready}, 64'd7);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: mtime counts edges since reset release.
        sel = 1'b0;
        tick(4);
        rd(BASE + 32'hBFF8, 8'd0, 4'h5, d, rs, ri);
        check("t1_lo", d, 64'd4);
        check("t1_lo_resp", rs, 64'd0);
        check("t1_rid", ri, 64'h5);
        rd(BASE + 32'hBFFC, 8'd0, 4'h1, d, rs, ri);
        check("t1_hi", d, 64'd0);
        check("t1_mtip", mtip0, 64'd0);

        // Test 2: hart 1 timer fires one cycle after mtime reaches 0x40.
        wr(BASE + 32'hBFF8, 32'd0, 4'hF, 4'h2, 1'b0, bs, bi);
        t0 = t_last;
        check("t2_mtime_wr", bs, 64'd0);
        wr(BASE + 32'h4008, 32'h40, 4'hF, 4'h2, 1'b0, bs, bi);
        wr(BASE + 32'h400C, 32'h0, 4'hF, 4'h2, 1'b0, bs, bi);
        check("t2_cmp_resp", bs, 64'd0);
        while (cyc < t0 + 64) tick(1);
        check("t2_mtip_before", mtip0, 64'd0);
        tick(1);
        check("t2_mtip_rise", mtip0, 64'b10);
        fork
            send_aw(BASE + 32'h400C, 8'd0, 4'h2);
            send_w(32'hFFFF_FFFF, 4'hF, 1, nacc);
        join
        check("t2_mtip_lag", mtip0, 64'b10);
        wait_b(bs, bi);
        check("t2_mtip_fall", mtip0, 64'd0);

        // Test 3: msip is bit 0 of byte 0 only.
        wr(BASE + 32'h0000, 32'hFFFF_FFFF, 4'b0001, 4'h3, 1'b0, bs, bi);
        check("t3_msip_set", msip0, 64'b01);
        rd(BASE + 32'h0000, 8'd0, 4'h0, d, rs, ri);
        check("t3_msip_rd", d, 64'h1);
        wr(BASE + 32'h0004, 32'hFFFF_FFFF, 4'b0001, 4'h3, 1'b0, bs, bi);
        check("t3_msip1_set", msip0, 64'b11);
        wr(BASE + 32'h0004, 32'h0, 4'b0001, 4'h3, 1'b0, bs, bi);
        check("t3_msip1_clr", msip0, 64'b01);
        wr(BASE + 32'h0000, 32'h0, 4'b1110, 4'h3, 1'b0, bs, bi);
        check("t3_strb_mask", msip0, 64'b01);
        fork
            rd(BASE + 32'h0000, 8'd0, 4'h0, d, rs, ri);
            wr(BASE + 32'h0000, 32'h0, 4'b0001, 4'h3, 1'b0, bs, bi);
        join
        check("t3_rd_prewrite", d, 64'h1);
        check("t3_msip_clr", msip0, 64'b00);
        rd(BASE + 32'h0000, 8'd0, 4'h0, d, rs, ri);
        check("t3_msip_rd0", d, 64'h0);

        // Test 4: mtime wrap, W-before-AW and same-cycle AW/W.
        wr(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 4'hA, 1'b1, bs, bi);
        check("t4_wfirst_resp", {bs, bi}, {58'd0, 2'b00, 4'hA});
        fork
            send_aw(BASE + 32'hBFF8, 8'd0, 4'h3);
            send_w(32'hFFFF_FFFE, 4'hF, 1, nacc);
        join
        fork
            begin
                rd(BASE + 32'hBFF8, 8'd0, 4'h0, d1, rs, ri);
                rd(BASE + 32'hBFF8, 8'd0, 4'h0, d2, rs, ri);
            end
            wait_b(bs, bi);
        join
        check("t4_same_resp", {bs, bi}, {58'd0, 2'b00, 4'h3});
        check("t4_lo_pre", d1, 64'hFFFF_FFFE);
        check("t4_lo_wrap", d2, 64'h0);
        rd(BASE + 32'hBFFC, 8'd0, 4'h0, d, rs, ri);
        check("t4_hi_wrap", d, 64'h0);

        // Test 5: unmapped accesses on the single-hart instance.
        sel = 1'b1;
        rd(BASE + 32'h4008, 8'd0, 4'h7, d, rs, ri);
        check("t5_hart_oob", {rs, d}, {30'd0, 2'b10, 32'h0});
        rd(BASE + 32'h0002, 8'd0, 4'h7, d, rs, ri);
        check("t5_misalign", {rs, d}, {30'd0, 2'b10, 32'h0});
        rd(32'h1002_0000, 8'd0, 4'h7, d, rs, ri);
        check("t5_window", {rs, d}, {30'd0, 2'b10, 32'h0});
        rd(BASE + 32'hBFF8, 8'd1, 4'h7, d, rs, ri);
        check("t5_rd_len", {rs, d}, {30'd0, 2'b10, 32'h0});
        send_aw(BASE + 32'h4000, 8'd3, 4'h6);
        send_w(32'h0, 4'hF, 4, nacc);
        check("t5_beats", nacc, 64'd4);
        wait_b(bs, bi);
        check("t5_burst_resp", {bs, bi}, {58'd0, 2'b10, 4'h6});
        flag = 1'b0;
        for (int i = 0; i < 4; i++) begin flag |= bvalid_m; tick(1); end
        check("t5_single_b", flag, 64'd0);
        rd(BASE + 32'h4000, 8'd0, 4'h0, d, rs, ri);
        check("t5_cmp_kept", {rs, d}, {30'd0, 2'b00, 32'hFFFF_FFFF});
        check("t5_irq", {mtip1, msip1}, 64'd0);

        // Test 6: /4 prescaler, stalled read response, reset mid-write.
        rd(BASE + 32'hBFF8, 8'd0, 4'h0, d1, rs, ri);
        tick(6);
        rd(BASE + 32'hBFF8, 8'd0, 4'h0, d2, rs, ri);
        tick(2);
        rd(BASE + 32'hBFF8, 8'd0, 4'h0, d3, rs, ri);
        check("t6_div8", d2 - d1, 64'd2);
        check("t6_div4", d3 - d2, 64'd1);
        araddr = BASE + 32'hBFF8; arlen = 8'd0; arid = 4'h9; arvalid = 1'b1; rready = 1'b0;
        tick(1);
        d = rdata_m;
        flag = 1'b1;
        for (int i = 0; i < 10; i++) begin
            flag &= rvalid_m && (rdata_m == d) && !arready_m && (rid_m == 4'h9);
            tick(1);
        end
        arvalid = 1'b0;
        check("t6_hold", flag, 64'd1);
        check("t6_held_val", d - d3, 64'd0);
        rready = 1'b1;
        tick(1);
        check("t6_r_done", rvalid_m, 64'd0);
        rready = 1'b0;
        wr(BASE + 32'h0000, 32'h1, 4'h1, 4'h4, 1'b0, bs, bi);
        check("t6_msip_set", msip1, 64'd1);
        send_aw(BASE + 32'h0000, 8'd0, 4'h4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_irq", {mtip0, msip0, mtip1, msip1}, 64'd0);
        check("t6_rst_bus", {bvalid_m, rvalid_m, awready_m, wready_m}, 64'b0011);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        send_w(32'h1, 4'h1, 1, nacc);
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin flag |= bvalid_m; tick(1); end
        check("t6_no_b", flag, 64'd0);
        check("t6_msip_after", msip1, 64'd0);
        rd(BASE + 32'h4004, 8'd0, 4'h0, d, rs, ri);
        check("t6_cmp_rst", d, 64'hFFFF_FFFF);
        rd(BASE + 32'hBFFC, 8'd0, 4'h0, d, rs, ri);
        check("t6_mtime_hi", d, 64'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
